// File: rtl/pll_reset_seq_pkg.sv
// Shared state encoding, legal parameter limits and counter width helper for pll_reset_seq.
package pll_reset_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_FILTER    = 2'd1;
    localparam state_t ST_HOLD      = 2'd2;
    localparam state_t ST_RUN       = 2'd3;

    localparam int MAX_LOCK_CYCLES = 65535;
    localparam int MAX_RST_HOLD    = 255;
    localparam int MAX_CE_DIVIDE   = 128;

    // Never returns zero, so a counter always has at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_ce_div.sv
// Clock-enable divider: one-cycle CE pulse every DIVIDE cycles while EN is high,
// with the phase restarting whenever EN drops.
module pll_ce_div
    import pll_reset_seq_pkg::*;
#(
    parameter int DIVIDE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic CE
);

    localparam int CW = cnt_width(DIVIDE);

    if (DIVIDE < 1 || DIVIDE > MAX_CE_DIVIDE) begin : g_bad_divide
        $error("pll_ce_div: DIVIDE out of range 1..128");
    end

    logic [CW-1:0] phase;

    // EN is the next-cycle RUN flag, so the first pulse lands on the first RUN cycle.
    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            phase <= '0;
            CE    <= 1'b0;
        end else begin
            CE <= (phase == '0);
            if (phase == CW'(DIVIDE - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and reset release sequencer with optional CE generation.
// CE dividers are built only when PLL_RESET_SEQ_CE_GEN_EN is defined; otherwise CE0/CE1 are tied high.
//
// state     | meaning
// WAIT_LOCK | PLL not locked, downstream held in reset
// FILTER    | counting consecutive LOCKED-high cycles
// HOLD      | lock qualified, stretching reset for RST_HOLD cycles
// RUN       | reset released, READY high, CEs active
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int LOCK_CYCLES = 16,
    parameter int RST_HOLD    = 8,
    parameter int CE0_DIVIDE  = 1,
    parameter int CE1_DIVIDE  = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic LOCKED,
    output logic RST_OUT,
    output logic READY,
    output logic CE0,
    output logic CE1
);

    localparam int LW = cnt_width(LOCK_CYCLES + 1);
    localparam int HW = cnt_width(RST_HOLD + 1);

    if (LOCK_CYCLES < 1 || LOCK_CYCLES > MAX_LOCK_CYCLES) begin : g_bad_lock
        $error("pll_reset_seq: LOCK_CYCLES out of range 1..65535");
    end
    if (RST_HOLD < 0 || RST_HOLD > MAX_RST_HOLD) begin : g_bad_hold
        $error("pll_reset_seq: RST_HOLD out of range 0..255");
    end
    if (CE0_DIVIDE < 1 || CE0_DIVIDE > MAX_CE_DIVIDE) begin : g_bad_ce0
        $error("pll_reset_seq: CE0_DIVIDE out of range 1..128");
    end
    if (CE1_DIVIDE < 1 || CE1_DIVIDE > MAX_CE_DIVIDE) begin : g_bad_ce1
        $error("pll_reset_seq: CE1_DIVIDE out of range 1..128");
    end

    state_t        state,    state_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            ST_WAIT_LOCK: begin
                lock_nxt = '0;
                hold_nxt = '0;
                if (LOCKED) begin
                    lock_nxt  = LW'(1);
                    state_nxt = (LOCK_CYCLES == 1) ? ST_HOLD : ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (!LOCKED) begin
                    state_nxt = ST_WAIT_LOCK;
                    lock_nxt  = '0;
                    hold_nxt  = '0;
                end else if (lock_cnt + 1'b1 >= LW'(LOCK_CYCLES)) begin
                    state_nxt = ST_HOLD;
                    lock_nxt  = LW'(LOCK_CYCLES);
                    hold_nxt  = '0;
                end else begin
                    lock_nxt = lock_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!LOCKED) begin
                    state_nxt = ST_WAIT_LOCK;
                    lock_nxt  = '0;
                    hold_nxt  = '0;
                end else if (hold_cnt >= HW'(RST_HOLD)) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!LOCKED) begin
                    state_nxt = ST_WAIT_LOCK;
                    lock_nxt  = '0;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                lock_nxt  = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_WAIT_LOCK;
            lock_cnt <= '0;
            hold_cnt <= '0;
            RST_OUT  <= 1'b1;
            READY    <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_nxt;
            hold_cnt <= hold_nxt;
            RST_OUT  <= (state_nxt != ST_RUN);
            READY    <= (state_nxt == ST_RUN);
        end
    end

`ifdef PLL_RESET_SEQ_CE_GEN_EN
    logic run_nxt;
    assign run_nxt = (state_nxt == ST_RUN);

    pll_ce_div #(.DIVIDE(CE0_DIVIDE)) u_ce0_div (
        .CLK (CLK),
        .RST (RST),
        .EN  (run_nxt),
        .CE  (CE0)
    );

    pll_ce_div #(.DIVIDE(CE1_DIVIDE)) u_ce1_div (
        .CLK (CLK),
        .RST (RST),
        .EN  (run_nxt),
        .CE  (CE1)
    );
`else
    assign CE0 = 1'b1;
    assign CE1 = 1'b1;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq: directed release/drop scenarios plus randomized LOCKED/RST traffic
// checked each cycle against a lock-streak model.
module tb_pll_reset_seq;

    localparam int L   = 4;
    localparam int H   = 2;
    localparam int D0  = 3;
    localparam int D1  = 1;
    localparam int LAT = L + H;

`ifdef PLL_RESET_SEQ_CE_GEN_EN
    localparam bit CE_EN = 1'b1;
`else
    localparam bit CE_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic LOCKED = 1'b0;
    logic RST_OUT, READY, CE0, CE1;

    int errors = 0;
    int checks = 0;

    pll_reset_seq #(
        .LOCK_CYCLES (L),
        .RST_HOLD    (H),
        .CE0_DIVIDE  (D0),
        .CE1_DIVIDE  (D1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .LOCKED  (LOCKED),
        .RST_OUT (RST_OUT),
        .READY   (READY),
        .CE0     (CE0),
        .CE1     (CE1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the sequencer is in RUN exactly when LOCKED has been sampled high on
    // more than LOCK_CYCLES+RST_HOLD consecutive edges since the last RST or drop.
    int streak = 0;
    bit mvalid = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            streak <= 0;
            mvalid <= 1'b1;
        end else if (!LOCKED) begin
            streak <= 0;
        end else begin
            streak <= streak + 1;
        end
    end

    always @(negedge CLK) begin
        bit run;
        int age;
        logic e0, e1;
        if (mvalid) begin
            run = (streak > LAT);
            age = streak - LAT - 1;
            e0  = CE_EN ? (run && (age % D0 == 0)) : 1'b1;
            e1  = CE_EN ? (run && (age % D1 == 0)) : 1'b1;
            chk("model_rst_out", RST_OUT, !run);
            chk("model_ready", READY, run);
            chk("model_ce0", CE0, e0);
            chk("model_ce1", CE1, e1);
        end
    end

    task automatic tick(input logic r, input logic l);
        RST    = r;
        LOCKED = l;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic       ce_idle;
        logic [5:0] ce0_pat;
        logic       r, l;
        ce_idle = CE_EN ? 1'b0 : 1'b1;
        ce0_pat = 6'b001001;

        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1);
            chk("rst_rst_out", RST_OUT, 1'b1);
            chk("rst_ready", READY, 1'b0);
            chk("rst_ce0", CE0, ce_idle);
            chk("rst_ce1", CE1, ce_idle);
        end

        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b1);
            chk("release_rst_out", RST_OUT, k < 6);
            chk("release_ready", READY, k >= 6);
            if (k >= 6) begin
                chk("run_ce0_pattern", CE0, CE_EN ? ce0_pat[k-6] : 1'b1);
                chk("run_ce1_pattern", CE1, 1'b1);
            end
        end

        tick(1'b0, 1'b0);
        chk("drop_rst_out", RST_OUT, 1'b1);
        chk("drop_ready", READY, 1'b0);
        chk("drop_ce0", CE0, ce_idle);
        chk("drop_ce1", CE1, ce_idle);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1);
            chk("relock_rst_out", RST_OUT, k < 6);
            chk("relock_ready", READY, k >= 6);
            if (k == 6) chk("relock_ce0_first", CE0, 1'b1);
        end

        tick(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, k != 3);
            chk("glitch_rst_out", RST_OUT, k < 10);
            chk("glitch_ready", READY, k >= 10);
        end

        tick(1'b1, 1'b1);
        chk("rst_in_run_rst_out", RST_OUT, 1'b1);
        chk("rst_in_run_ce0", CE0, ce_idle);

        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 24) != 0);
            tick(r, l);
        end

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 16: consecutive LOCKED-high cycles required before reset release sequence starts; legal range 1..65535.
REQ-002 SHALL have parameter RST_HOLD, default 8: cycles RST_OUT stays high after lock is qualified; legal range 0..255.
REQ-003 SHALL have parameter CE0_DIVIDE, default 1: period of CE0 in CLK cycles; legal range 1..128.
REQ-004 SHALL have parameter CE1_DIVIDE, default 1: period of CE1 in CLK cycles; legal range 1..128.
REQ-005 SHALL have port CLK  input  1  sole clock, driven from PLL CLKOUT0.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-007 SHALL have port LOCKED  input  1  PLL lock indication, synchronous to CLK.
REQ-008 SHALL have port RST_OUT  output  1  registered active-high reset for downstream logic.
REQ-009 SHALL have port READY  output  1  registered; high only in RUN state.
REQ-010 SHALL have port CE0  output  1  registered single-cycle clock enable emulating CLKOUT0 division.
REQ-011 SHALL have port CE1  output  1  registered single-cycle clock enable emulating CLKOUT1 division.

Function
REQ-012 SHALL implement states WAIT_LOCK, FILTER, HOLD, RUN.
REQ-013 WAIT_LOCK: LOCKED=1 -> FILTER with lock counter=1; else stay, counter=0.
REQ-014 FILTER: LOCKED=1 increments counter; counter reaching LOCK_CYCLES -> HOLD with hold counter=0; LOCK_CYCLES=1 goes WAIT_LOCK->HOLD directly.
REQ-015 HOLD: hold counter increments each cycle; after RST_HOLD cycles -> RUN; RST_HOLD=0 -> RUN on first HOLD cycle.
REQ-016 Latency: LOCKED sampled high continuously from edge 0 SHALL deassert RST_OUT and assert READY at edge LOCK_CYCLES+RST_HOLD.
REQ-017 LOCKED=0 sampled in FILTER, HOLD or RUN SHALL transition to WAIT_LOCK with counters cleared; next edge RST_OUT=1, READY=0, CE0=CE1=0.
REQ-018 RST_OUT SHALL be 1 in every state except RUN; READY SHALL equal (state==RUN).
REQ-019 CE0 SHALL pulse high one cycle every CE0_DIVIDE cycles only in RUN; first pulse on first RUN cycle; CE0_DIVIDE=1 -> CE0 constantly high in RUN.
REQ-020 CE1 SHALL follow REQ-019 with CE1_DIVIDE; CE0/CE1 phase counters SHALL restart on every RUN entry.
REQ-021 Counters SHALL saturate, never wrap; lock counter width $clog2(LOCK_CYCLES+1), CE counter width $clog2(divide).
REQ-022 Out-of-range parameters SHALL fail elaboration.

Reset
REQ-023 RST=1 SHALL on next edge force WAIT_LOCK, counters 0, RST_OUT=1, READY=0, CE0=0, CE1=0, regardless of LOCKED and current state.
REQ-024 RST SHALL take priority over all LOCKED-driven transitions.

Configuration
REQ-025 With macro PLL_RESET_SEQ_CE_GEN_EN defined, CE0/CE1 SHALL behave per REQ-019/020.
REQ-026 Without PLL_RESET_SEQ_CE_GEN_EN, CE0 and CE1 SHALL be constant 1, divider logic absent, ports retained.

Structure
REQ-027 Package pll_reset_seq_pkg SHALL hold the state enum and constants MAX_LOCK_CYCLES=65535, MAX_RST_HOLD=255, MAX_CE_DIVIDE=128.
REQ-028 Sub-module pll_ce_div (inputs CLK, RST, EN; output CE; parameter DIVIDE) SHALL be instantiated twice, EN=(state==RUN).

Verification (LOCK_CYCLES=4, RST_HOLD=2, CE0_DIVIDE=3, CE1_DIVIDE=1, macro defined unless stated)
REQ-029 RST=1 for 3 cycles, LOCKED=1 -> RST_OUT=1, READY=0, CE0=CE1=0 each cycle.
REQ-030 RST released, LOCKED high from edge 0 -> RST_OUT falls and READY rises exactly at edge 6.
REQ-031 LOCKED high 3 cycles, low 1, high again from edge 4 -> RST_OUT falls at edge 10.
REQ-032 In RUN for 6 cycles -> CE0 = 1,0,0,1,0,0; CE1 = 1 every cycle.
REQ-033 LOCKED dropped in RUN -> next edge RST_OUT=1, READY=0, CE0=CE1=0; re-lock releases after 6 edges.
REQ-034 Macro undefined, RST=1 -> CE0=CE1=1 while RST_OUT=1.
